// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett reducer family: default widths, the
// per-stage payload record and the moduli of the supported lattice schemes.
// Build option: BARRETT_LAZY_EN selects the lazy (un-corrected) result range.
package barrett_pkg;

    localparam int MW_DEF    = 32;
    localparam int TAG_W_DEF = 8;
    localparam int XW_DEF    = 2 * MW_DEF;
    localparam int KW_DEF    = $clog2(MW_DEF + 1);
    localparam int RW_DEF    = MW_DEF + 2;
    localparam int TW_DEF    = 2 * MW_DEF + 3;

    // Payload carried by one operand on its way through the reducer
    typedef struct packed {
        logic [XW_DEF-1:0]    x;
        logic [TW_DEF-1:0]    q;
        logic [RW_DEF-1:0]    r;
        logic [TAG_W_DEF-1:0] tag;
        logic                 err;
    } stage_t;

    localparam logic [MW_DEF-1:0] KYBER_M      = 32'h0000_0D01;
    localparam logic [MW_DEF:0]   KYBER_MU     = 33'h0_0000_13AF;
    localparam logic [KW_DEF-1:0] KYBER_K      = 6'd12;

    localparam logic [MW_DEF-1:0] DILITHIUM_M  = 32'h007F_E001;
    localparam logic [MW_DEF:0]   DILITHIUM_MU = 33'h0_0080_2007;
    localparam logic [KW_DEF-1:0] DILITHIUM_K  = 6'd23;

endpackage

// File: rtl/barrett_reduce_pipe_if.sv
// Operand/result stream of the Barrett reducer. The master drives operands
// and output-ready; the slave (the reducer) drives ready and results.
// Build option: BARRETT_LAZY_EN widens result_o to MW+2 bits.
interface barrett_reduce_pipe_if #(
    parameter int MW    = 32,
    parameter int TAG_W = 8
);
    localparam int XW = 2 * MW;
`ifdef BARRETT_LAZY_EN
    localparam int RW = MW + 2;
`else
    localparam int RW = MW;
`endif

    logic             in_valid_i;
    logic             in_ready_o;
    logic [XW-1:0]    x_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [RW-1:0]    result_o;
    logic [TAG_W-1:0] tag_o;
    logic             err_o;

    modport master (
        output in_valid_i, x_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, tag_o, err_o
    );

    modport slave (
        input  in_valid_i, x_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, tag_o, err_o
    );

endinterface

// File: rtl/barrett_correct.sv
// Final conditional subtraction of a Barrett reduction: takes r in [0, 3m)
// and folds it into [0, m). Purely combinational so callers choose where
// to register it.
module barrett_correct
    import barrett_pkg::*;
#(
    parameter int MW = MW_DEF
) (
    input  logic [MW+1:0] r_i,
    input  logic [MW-1:0] m_i,
    output logic [MW-1:0] res_o
);

    logic [MW+1:0] m1_s;
    logic [MW+1:0] m2_s;

    // Subtract 2m or m, whichever keeps the value non-negative and below m
    always_comb begin
        m1_s = {2'b00, m_i};
        m2_s = {1'b0, m_i, 1'b0};
        if (r_i >= m2_s) begin
            res_o = MW'(r_i - m2_s);
        end else if (r_i >= m1_s) begin
            res_o = MW'(r_i - m1_s);
        end else begin
            res_o = MW'(r_i);
        end
    end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Fully pipelined Barrett reducer r = x mod m with a runtime modulus,
// valid/ready backpressure, pass-through tags and range-error flagging.
// Build option: BARRETT_LAZY_EN drops the correction stage (latency 4,
// result in [0, 3m) on MW+2 bits); default is full reduction, latency 5.
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int MW    = MW_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_load_i,
    input  logic [MW-1:0]           cfg_m_i,
    input  logic [MW:0]             cfg_mu_i,
    input  logic [$clog2(MW+1)-1:0] cfg_k_i,
    output logic                    cfg_ack_o,
    barrett_reduce_pipe_if.slave    bus,
    output logic                    busy_o
);

    localparam int XW = 2 * MW;
    localparam int KW = $clog2(MW + 1);
    localparam int RW = MW + 2;
    localparam int TW = 2 * MW + 3;
`ifdef BARRETT_LAZY_EN
    localparam int OW = RW;
`else
    localparam int OW = MW;
`endif
    localparam logic [KW-1:0] K_ONE = KW'(1'b1);

    // Modulus configuration
    logic [MW-1:0]    cfg_m_r;
    logic [MW:0]      cfg_mu_r;
    logic [KW-1:0]    cfg_k_r;
    logic             cfg_ack_r;

    // Control
    logic             adv_s;
    logic             busy_s;
    logic             cfg_take_s;

    // Datapath combinational terms
    logic [KW:0]      sh_err_s;
    logic [KW-1:0]    sh_x_s;
    logic [KW:0]      sh_q_s;
    logic             err_in_s;
    logic [MW:0]      xs_s;
    logic [TW-1:0]    t_s;
    logic [RW-1:0]    qm_s;
    logic [RW-1:0]    r_s;

    // S1: captured operand
    logic             v1_r;
    logic [XW-1:0]    x1_r;
    logic [TAG_W-1:0] tag1_r;
    logic             err1_r;

    // S2: estimate product; only the low MW+2 bits of x are needed later
    logic             v2_r;
    logic [RW-1:0]    x2_r;
    logic [TW-1:0]    t2_r;
    logic [TAG_W-1:0] tag2_r;
    logic             err2_r;

    // S3: quotient times modulus
    logic             v3_r;
    logic [RW-1:0]    x3_r;
    logic [RW-1:0]    qm3_r;
    logic [TAG_W-1:0] tag3_r;
    logic             err3_r;

`ifndef BARRETT_LAZY_EN
    // S4: partially reduced remainder in [0, 3m)
    logic             v4_r;
    logic [RW-1:0]    r4_r;
    logic [TAG_W-1:0] tag4_r;
    logic             err4_r;
    logic [MW-1:0]    corr_s;
`endif

    // Output stage
    logic             out_valid_r;
    logic [OW-1:0]    result_r;
    logic [TAG_W-1:0] tag_out_r;
    logic             err_out_r;

    // Stall decision, pipeline occupancy and whether a config load is safe now
    always_comb begin
        adv_s = ~out_valid_r | bus.out_ready_i;
`ifdef BARRETT_LAZY_EN
        busy_s = v1_r | v2_r | v3_r | out_valid_r;
`else
        busy_s = v1_r | v2_r | v3_r | v4_r | out_valid_r;
`endif
        cfg_take_s = cfg_load_i & ~busy_s & ~bus.in_valid_i;
    end

    // Arithmetic between stage registers; every shift uses the runtime k
    always_comb begin
        sh_err_s = {cfg_k_r, 1'b0};
        sh_x_s   = cfg_k_r - K_ONE;
        sh_q_s   = {1'b0, cfg_k_r} + {1'b0, K_ONE};
        err_in_s = ((bus.x_i >> sh_err_s) != {XW{1'b0}});
        xs_s     = (MW + 1)'(x1_r >> sh_x_s);
        t_s      = TW'(xs_s) * TW'(cfg_mu_r);
        qm_s     = RW'(t2_r >> sh_q_s) * RW'(cfg_m_r);
        r_s      = x3_r - qm3_r;
    end

`ifndef BARRETT_LAZY_EN
    barrett_correct #(
        .MW (MW)
    ) u_correct (
        .r_i   (r4_r),
        .m_i   (cfg_m_r),
        .res_o (corr_s)
    );
`endif

    // Latch a new modulus only while the pipeline is empty and idle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_m_r   <= '0;
            cfg_mu_r  <= '0;
            cfg_k_r   <= '0;
            cfg_ack_r <= 1'b0;
        end else begin
            cfg_ack_r <= cfg_take_s;
            if (cfg_take_s) begin
                cfg_m_r  <= cfg_m_i;
                cfg_mu_r <= cfg_mu_i;
                cfg_k_r  <= cfg_k_i;
            end
        end
    end

    // Pipeline registers; all stages advance together or hold together
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v1_r        <= 1'b0;
            x1_r        <= '0;
            tag1_r      <= '0;
            err1_r      <= 1'b0;
            v2_r        <= 1'b0;
            x2_r        <= '0;
            t2_r        <= '0;
            tag2_r      <= '0;
            err2_r      <= 1'b0;
            v3_r        <= 1'b0;
            x3_r        <= '0;
            qm3_r       <= '0;
            tag3_r      <= '0;
            err3_r      <= 1'b0;
`ifndef BARRETT_LAZY_EN
            v4_r        <= 1'b0;
            r4_r        <= '0;
            tag4_r      <= '0;
            err4_r      <= 1'b0;
`endif
            out_valid_r <= 1'b0;
            result_r    <= '0;
            tag_out_r   <= '0;
            err_out_r   <= 1'b0;
        end else if (adv_s) begin
            v1_r        <= bus.in_valid_i;
            x1_r        <= bus.x_i;
            tag1_r      <= bus.tag_i;
            err1_r      <= err_in_s;
            v2_r        <= v1_r;
            x2_r        <= x1_r[RW-1:0];
            t2_r        <= t_s;
            tag2_r      <= tag1_r;
            err2_r      <= err1_r;
            v3_r        <= v2_r;
            x3_r        <= x2_r;
            qm3_r       <= qm_s;
            tag3_r      <= tag2_r;
            err3_r      <= err2_r;
`ifdef BARRETT_LAZY_EN
            out_valid_r <= v3_r;
            result_r    <= r_s;
            tag_out_r   <= tag3_r;
            err_out_r   <= err3_r;
`else
            v4_r        <= v3_r;
            r4_r        <= r_s;
            tag4_r      <= tag3_r;
            err4_r      <= err3_r;
            out_valid_r <= v4_r;
            result_r    <= corr_s;
            tag_out_r   <= tag4_r;
            err_out_r   <= err4_r;
`endif
        end
    end

    assign bus.in_ready_o  = adv_s;
    assign bus.out_valid_o = out_valid_r;
    assign bus.result_o    = result_r;
    assign bus.tag_o       = tag_out_r;
    assign bus.err_o       = err_out_r;
    assign cfg_ack_o       = cfg_ack_r;
    assign busy_o          = busy_s;

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Scoreboard bench for barrett_reduce_pipe (default build, full reduction).
module tb_barrett_reduce_pipe;
    import barrett_pkg::*;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_load;
    logic [31:0] cfg_m;
    logic [32:0] cfg_mu;
    logic [5:0]  cfg_k;
    logic        cfg_ack;
    logic        busy;

    barrett_reduce_pipe_if #(.MW(MW_DEF), .TAG_W(TAG_W_DEF)) bus ();

    barrett_reduce_pipe #(.MW(MW_DEF), .TAG_W(TAG_W_DEF)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cfg_load_i (cfg_load),
        .cfg_m_i    (cfg_m),
        .cfg_mu_i   (cfg_mu),
        .cfg_k_i    (cfg_k),
        .cfg_ack_o  (cfg_ack),
        .bus        (bus),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int          tests     = 0;
    int          errors    = 0;
    int          out_count = 0;
    int          cyc       = 0;
    stage_t      sb[$];
    logic [31:0] model_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operand, wait (bounded) for acceptance, then log its expectation
    task automatic send(input logic [63:0] x, input logic [7:0] tag,
                        input logic [63:0] exp_r, input logic exp_err);
        int     n;
        logic   ok;
        stage_t e;
        bus.in_valid_i = 1'b1;
        bus.x_i        = x;
        bus.tag_i      = tag;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid_i = 1'b0;
        if (ok) begin
            e     = '0;
            e.x   = x;
            e.r   = exp_r[33:0];
            e.tag = tag;
            e.err = exp_err;
            sb.push_back(e);
        end else begin
            check("accept_timeout", 64'(ok), 64'd1);
        end
    endtask

    task automatic load_cfg(input logic [31:0] m, input logic [32:0] mu,
                            input logic [5:0] k, input logic exp_ack);
        cfg_load = 1'b1;
        cfg_m    = m;
        cfg_mu   = mu;
        cfg_k    = k;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        check("cfg_ack", 64'(cfg_ack), 64'(exp_ack));
        @(posedge clk);
        #1;
        check("cfg_ack_pulse_end", 64'(cfg_ack), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Cycle counter for throughput measurements
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pop and compare on every output transfer, check hold stability
    initial begin : monitor
        stage_t      e;
        logic        held;
        logic [31:0] h_res;
        logic [7:0]  h_tag;
        logic        h_err;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid",  64'(bus.out_valid_o), 64'd1);
                    check("hold_result", 64'(bus.result_o), 64'(h_res));
                    check("hold_tag",    64'(bus.tag_o), 64'(h_tag));
                    check("hold_err",    64'(bus.err_o), 64'(h_err));
                end
                if (bus.out_valid_o && bus.out_ready_i) begin
                    out_count++;
                    if (sb.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_output: got result 0x%0h tag 0x%0h, required no output",
                                 bus.result_o, bus.tag_o);
                    end else begin
                        e = sb.pop_front();
                        check("out_tag", 64'(bus.tag_o), 64'(e.tag));
                        check("out_err", 64'(bus.err_o), 64'(e.err));
                        if (!e.err) begin
                            check("out_result", 64'(bus.result_o), 64'(e.r));
                        end
                    end
                end
                held  = bus.out_valid_o && !bus.out_ready_i;
                h_res = bus.result_o;
                h_tag = bus.tag_o;
                h_err = bus.err_o;
            end
        end
    end

    initial begin : stimulus
        logic [63:0] xs [8];
        logic [63:0] rx;
        int          lat;
        int          c0;
        logic        saw_stall;

        rst_n          = 1'b0;
        cfg_load       = 1'b0;
        cfg_m          = 32'd0;
        cfg_mu         = 33'd0;
        cfg_k          = 6'd0;
        bus.in_valid_i = 1'b0;
        bus.x_i        = 64'd0;
        bus.tag_i      = 8'd0;
        bus.out_ready_i = 1'b1;
        model_m        = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_cfg_ack",   64'(cfg_ack), 64'd0);
        check("rst_result",    64'(bus.result_o), 64'd0);
        check("rst_tag",       64'(bus.tag_o), 64'd0);
        check("rst_err",       64'(bus.err_o), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready_o), 64'd1);
        rst_n = 1'b1;

        // Kyber
        load_cfg(KYBER_M, KYBER_MU, KYBER_K, 1'b1);
        model_m = 32'h0000_0D01;
        send(64'hFF_FFFF, 8'h11, 64'h950, 1'b0);
        lat = 1;
        while (!bus.out_valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("kyber_latency", 64'(lat), 64'(LAT));
        send(64'h0D01, 8'h12, 64'h0, 1'b0);
        send(64'h0,    8'h13, 64'h0, 1'b0);
        send(64'h0D00, 8'h14, 64'hD00, 1'b0);
        send(64'h12_3456,  8'h15, 64'h4F0, 1'b0);
        send(64'h100_0000, 8'h16, 64'h0, 1'b1);
        send(64'hFF_FFFF,  8'h17, 64'h950, 1'b0);
        drain();

        // Dilithium
        load_cfg(DILITHIUM_M, DILITHIUM_MU, DILITHIUM_K, 1'b1);
        model_m = 32'h007F_E001;
        send(64'h27F_6005, 8'h21, 64'h0, 1'b0);
        send(64'h7F_E000,  8'h22, 64'h7F_E000, 1'b0);
        send(64'h3FFF_FFFF_FFFF, 8'h23, 64'h3FFF_FFFF_FFFF % 64'(model_m), 1'b0);
        drain();
        c0 = cyc;
        for (int i = 0; i < 64; i++) begin
            rx = {$urandom(), $urandom()};
            rx[63:46] = 18'd0;
            send(rx, 8'(i), rx % 64'(model_m), 1'b0);
        end
        check("stream_accept_cycles", 64'(cyc - c0), 64'd64);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        #1;
        check("stream_all_out", 64'(sb.size()), 64'd0);
        drain();

        // Backpressure
        for (int i = 0; i < 8; i++) begin
            xs[i] = 64'h1_0000_0000 * 64'(i + 1) + 64'h0123_4567;
        end
        saw_stall = 1'b0;
        bus.out_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(xs[i], 8'h80 + 8'(i), xs[i] % 64'(model_m), 1'b0);
                end
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!bus.in_ready_o) saw_stall = 1'b1;
                end
                @(posedge clk);
                #1;
                bus.out_ready_i = 1'b1;
            end
        join
        check("bp_in_ready_fell", 64'(saw_stall), 64'd1);
        drain();

        // Config request while busy is ignored; old modulus stays in use
        send(64'h1234_5678, 8'h31, 64'h1234_5678 % 64'(model_m), 1'b0);
        load_cfg(KYBER_M, KYBER_MU, KYBER_K, 1'b0);
        send(64'h0FF_FFFF, 8'h32, 64'h0FF_FFFF % 64'(model_m), 1'b0);
        drain();
        load_cfg(KYBER_M, KYBER_MU, KYBER_K, 1'b1);
        model_m = 32'h0000_0D01;
        send(64'hFF_FFFF, 8'h33, 64'h950, 1'b0);
        drain();

        // Reset with three operands in flight
        send(64'h11, 8'h41, 64'h11, 1'b0);
        send(64'h22, 8'h42, 64'h22, 1'b0);
        send(64'h33, 8'h43, 64'h33, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("inflight_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("inflight_rst_busy", 64'(busy), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        c0 = out_count;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_emit", 64'(out_count - c0), 64'd0);

        load_cfg(KYBER_M, KYBER_MU, KYBER_K, 1'b1);
        send(64'h0D01, 8'h51, 64'h0, 1'b0);
        send(64'hFF_FFFF, 8'h52, 64'h950, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
